// File: rtl/dma_buffer_packer.sv
// dma_buffer_packer
// Read-side buffer for the DMA read path. Full-width memory words are queued
// in a small word FIFO and handed to the write side one element at a time
// (byte, halfword, word or doubleword), sign- or zero-extended to the word
// width, starting at a configurable byte offset inside the first word.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              latches data_type_i / sign_ext_i / src_offset_i
//   data_type_i          0 word, 1 halfword, 2 byte, 3 doubleword (64-bit only)
//   sign_ext_i           1 sign-extend element, 0 zero-extend
//   src_offset_i         start byte within the first word
//   flush_i              synchronous clear of FIFO and byte pointer
//   push_i, push_data_i  word write from the read master
//   full_o, alm_full_o   FIFO full / count >= FIFO_DEPTH-1
//   pop_i                consume current element
//   empty_o, data_o      element availability and extended element
//   count_o              words stored
module dma_buffer_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int OFF_W      = $clog2(DATA_WIDTH/8)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            start_i,
   input  logic [1:0]                      data_type_i,
   input  logic                            sign_ext_i,
   input  logic [OFF_W-1:0]                src_offset_i,
   input  logic                            flush_i,
   input  logic                            push_i,
   input  logic [DATA_WIDTH-1:0]           push_data_i,
   output logic                            full_o,
   output logic                            alm_full_o,
   input  logic                            pop_i,
   output logic                            empty_o,
   output logic [DATA_WIDTH-1:0]           data_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   // Element size is kept as log2(bytes): 0=byte, 1=half, 2=word, 3=dword.
   function automatic logic [1:0] type_to_lg(input logic [1:0] dt);
      logic [1:0] lg;
      case (dt)
         2'd1:    lg = 2'd1;
         2'd2:    lg = 2'd0;
         2'd3:    lg = (DATA_WIDTH == 64) ? 2'd3 : 2'd2;
         default: lg = 2'd2;
      endcase
      return lg;
   endfunction

   // Select bytes [ptr +: 2**lg] of the word and extend to the full width.
   function automatic logic [DATA_WIDTH-1:0] extend_elem(
      input logic [DATA_WIDTH-1:0] word,
      input logic [OFF_W-1:0]      ptr,
      input logic [1:0]            lg,
      input logic                  sx
   );
      logic [DATA_WIDTH-1:0] sh;
      logic [DATA_WIDTH-1:0] res;
      logic                  fill;
      int                    nbits;
      sh    = word >> {ptr, 3'b000};
      nbits = 8 << lg;
      if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
      fill  = sx & sh[nbits-1];
      for (int i = 0; i < DATA_WIDTH; i++) begin
         res[i] = (i < nbits) ? sh[i] : fill;
      end
      return res;
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [OFF_W-1:0]      byte_ptr_q, byte_ptr_d;
   logic [1:0]            esize_lg_q, esize_lg_d;
   logic                  sext_q, sext_d;

   logic                  push_ok, pop_ok, end_word, retire, mem_we;
   logic [OFF_W:0]        esize_cur, esize_new;
   logic [1:0]            new_lg;
   logic [OFF_W-1:0]      aligned_off;

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == CNT_W'(FIFO_DEPTH));
   assign alm_full_o = (count_q >= CNT_W'(FIFO_DEPTH - 1));
   assign count_o    = count_q;
   assign data_o     = empty_o ? '0
                     : extend_elem(mem_q[rd_ptr_q], byte_ptr_q, esize_lg_q, sext_q);

   always_comb begin
      new_lg      = type_to_lg(data_type_i);
      esize_new   = (OFF_W+1)'(1) << new_lg;
      esize_cur   = (OFF_W+1)'(1) << esize_lg_q;
      // Clearing the low bits aligns the offset down to the element size;
      // a full-word element masks the whole offset away.
      aligned_off = src_offset_i & ~(esize_new[OFF_W-1:0] - OFF_W'(1));
      push_ok     = push_i & ~full_o;
      pop_ok      = pop_i & ~empty_o;
      end_word    = (({1'b0, byte_ptr_q} + esize_cur) == (OFF_W+1)'(BYTES));
      retire      = pop_ok & end_word;
      mem_we      = push_ok & ~flush_i;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      byte_ptr_d = byte_ptr_q;
      esize_lg_d = esize_lg_q;
      sext_d     = sext_q;

      if (start_i) begin
         esize_lg_d = new_lg;
         sext_d     = sign_ext_i;
      end

      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         byte_ptr_d = '0;
      end else begin
         if (pop_ok) begin
            if (end_word) begin
               rd_ptr_d   = rd_ptr_q + AW'(1);
               byte_ptr_d = '0;
            end else begin
               byte_ptr_d = byte_ptr_q + esize_cur[OFF_W-1:0];
            end
         end
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         case ({push_ok, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end

      // A new transfer starts at its aligned offset, also when flushing.
      if (start_i) byte_ptr_d = aligned_off;
   end

   // Control state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         byte_ptr_q <= '0;
         esize_lg_q <= 2'd2;
         sext_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         byte_ptr_q <= byte_ptr_d;
         esize_lg_q <= esize_lg_d;
         sext_q     <= sext_d;
      end
   end

   // Word storage; contents are qualified by count, so no reset is needed
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: tb/tb_dma_buffer_packer.sv
module tb_dma_buffer_packer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start, sx, flush, push, pop;
   logic [1:0]  dt;
   logic [1:0]  off32;
   logic [2:0]  off64;
   logic [31:0] pd32;
   logic [63:0] pd64;

   logic        full32, alm32, empty32;
   logic [31:0] data32;
   logic [2:0]  count32;
   logic        full64, alm64, empty64;
   logic [63:0] data64;
   logic [2:0]  count64;

   dma_buffer_packer #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut32 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_type_i(dt),
      .sign_ext_i(sx), .src_offset_i(off32), .flush_i(flush), .push_i(push),
      .push_data_i(pd32), .full_o(full32), .alm_full_o(alm32), .pop_i(pop),
      .empty_o(empty32), .data_o(data32), .count_o(count32));

   dma_buffer_packer #(.DATA_WIDTH(64), .FIFO_DEPTH(4)) dut64 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_type_i(dt),
      .sign_ext_i(sx), .src_offset_i(off64), .flush_i(flush), .push_i(push),
      .push_data_i(pd64), .full_o(full64), .alm_full_o(alm64), .pop_i(pop),
      .empty_o(empty64), .data_o(data64), .count_o(count64));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      start = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0;
   endtask

   task automatic begin_xfer(input logic [1:0] t, input logic s, input logic [1:0] o32,
                             input logic [2:0] o64);
      flush = 1'b1; start = 1'b1; dt = t; sx = s; off32 = o32; off64 = o64;
      step();
      idle();
   endtask

   typedef struct packed {
      logic [1:0]       dt;
      logic             sx;
      logic [1:0]       off;
      logic [1:0]       nw;
      logic [2:0]       np;
      logic [1:0]       rc;
      logic [1:0][31:0] w;
      logic [3:0][31:0] e;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] t, input logic s, input logic [1:0] o,
                               input int nw, input int np, input int rc,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
      vec_t v;
      v.dt = t; v.sx = s; v.off = o;
      v.nw = 2'(nw); v.np = 3'(np); v.rc = 2'(rc);
      v.w = {w1, w0};
      v.e = {e3, e2, e1, e0};
      return v;
   endfunction

   // Reference model: queue of words plus element size in bytes and byte pointer
   logic [31:0] mq[$];
   int          m_es, m_ptr;
   logic        m_sx;

   function automatic int es_of(input logic [1:0] t);
      case (t)
         2'd1:    return 2;
         2'd2:    return 1;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_elem(input logic [31:0] w, input int p,
                                              input int es, input logic s);
      logic [63:0] v, m;
      v = {32'h0, w} >> (8 * p);
      m = (64'd1 << (8 * es)) - 64'd1;
      v = v & m;
      if (s && v[8*es-1]) v = v | ~m;
      return v[31:0];
   endfunction

   vec_t tbl [6];

   initial begin
      logic [31:0] exp_d;
      logic        r_f, r_s, r_push, r_pop;
      logic [1:0]  r_dt, r_off;
      logic [31:0] r_d;
      int          n;

      rst_n = 1'b1; idle(); dt = 2'd0; sx = 1'b0; off32 = '0; off64 = '0;
      pd32 = '0; pd64 = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_count32", 64'(count32), 64'd0);
      chk("rst_flags32", {61'd0, empty32, full32, alm32}, 64'b100);
      chk("rst_data32",  64'(data32), 64'd0);
      chk("rst_flags64", {61'd0, empty64, full64, alm64}, 64'b100);
      #7 rst_n = 1'b1;
      step();

      tbl[0] = mk(2'd2, 1'b0, 2'd0, 1, 4, 0, 32'h44332211, 32'h0,
                  32'h11, 32'h22, 32'h33, 32'h44);
      tbl[1] = mk(2'd1, 1'b1, 2'd0, 1, 2, 0, 32'h80017FFF, 32'h0,
                  32'h00007FFF, 32'hFFFF8001, 32'h0, 32'h0);
      tbl[2] = mk(2'd1, 1'b0, 2'd0, 1, 2, 0, 32'h80017FFF, 32'h0,
                  32'h00007FFF, 32'h00008001, 32'h0, 32'h0);
      tbl[3] = mk(2'd2, 1'b0, 2'd2, 2, 4, 1, 32'h44332211, 32'h88776655,
                  32'h33, 32'h44, 32'h55, 32'h66);
      tbl[4] = mk(2'd1, 1'b0, 2'd3, 2, 2, 1, 32'h44332211, 32'h88776655,
                  32'h4433, 32'h6655, 32'h0, 32'h0);
      tbl[5] = mk(2'd2, 1'b1, 2'd0, 1, 2, 1, 32'h000080FF, 32'h0,
                  32'hFFFFFFFF, 32'hFFFFFF80, 32'h0, 32'h0);

      for (int i = 0; i < 6; i++) begin
         begin_xfer(tbl[i].dt, tbl[i].sx, tbl[i].off, 3'd0);
         for (int k = 0; k < int'(tbl[i].nw); k++) begin
            push = 1'b1; pd32 = tbl[i].w[k];
            step();
         end
         push = 1'b0;
         chk($sformatf("vec%0d_count", i), 64'(count32), 64'(tbl[i].nw));
         for (int k = 0; k < int'(tbl[i].np); k++) begin
            chk($sformatf("vec%0d_elem%0d", i, k), 64'(data32), 64'(tbl[i].e[k]));
            pop = 1'b1;
            step();
         end
         pop = 1'b0;
         chk($sformatf("vec%0d_left", i), 64'(count32), 64'(tbl[i].rc));
         chk($sformatf("vec%0d_empty", i), 64'(empty32), 64'(tbl[i].rc == 2'd0));
      end

      // Fill to full, overflow, and overflow alongside a retiring pop
      begin_xfer(2'd0, 1'b0, 2'd0, 3'd0);
      for (int k = 1; k <= 5; k++) begin
         push = 1'b1; pd32 = 32'hA000_0000 + 32'(k);
         step();
         if (k == 2) chk("fill2_alm", {62'd0, alm32, full32}, 64'b00);
         if (k == 3) chk("fill3_alm", {62'd0, alm32, full32}, 64'b10);
         if (k >= 4) chk($sformatf("fill%0d_full", k), {59'd0, count32, alm32, full32},
                         {59'd4, 2'b11});
      end
      push = 1'b1; pop = 1'b1; pd32 = 32'hA000_0006;
      step();
      idle();
      chk("ovf_pop_count", 64'(count32), 64'd3);
      for (int k = 2; k <= 4; k++) begin
         chk($sformatf("drain_w%0d", k), 64'(data32), 64'(32'hA000_0000 + 32'(k)));
         pop = 1'b1;
         step();
      end
      pop = 1'b0;
      chk("drain_empty", 64'(empty32), 64'd1);

      // Flush mid-word with a concurrent push; config survives the flush
      begin_xfer(2'd2, 1'b0, 2'd0, 3'd0);
      push = 1'b1; pd32 = 32'hB3B2B1B0; step();
      pd32 = 32'hC3C2C1C0; step();
      push = 1'b0;
      pop = 1'b1; step(); pop = 1'b0;
      chk("fl_before", 64'(data32), 64'h B1);
      flush = 1'b1; push = 1'b1; pd32 = 32'hDEADBEEF; dt = 2'd0;
      step();
      idle();
      chk("fl_count", 64'(count32), 64'd0);
      chk("fl_empty_data", {empty32, 31'd0, data32}, {1'b1, 63'd0});
      push = 1'b1; pd32 = 32'h12345678; step(); push = 1'b0;
      chk("fl_new_b0", 64'(data32), 64'h78);
      pop = 1'b1; step(); pop = 1'b0;
      chk("fl_new_b1", 64'(data32), 64'h56);

      // 64-bit doubleword, byte stream, then asynchronous reset
      begin_xfer(2'd3, 1'b1, 2'd0, 3'd0);
      push = 1'b1; pd64 = 64'h8000000000000001; step(); push = 1'b0;
      chk("dw_data", data64, 64'h8000000000000001);
      pop = 1'b1; step(); pop = 1'b0;
      chk("dw_empty", 64'(empty64), 64'd1);
      begin_xfer(2'd2, 1'b0, 2'd0, 3'd0);
      push = 1'b1; pd64 = 64'h0807060504030201; step(); push = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("b64_%0d", k), data64, 64'(k + 1));
         pop = 1'b1;
         step();
      end
      pop = 1'b0;
      chk("b64_count", 64'(count64), 64'd0);
      push = 1'b1; pd64 = 64'hFFFF_FFFF_FFFF_FFF0; step(); step(); push = 1'b0;
      pop = 1'b1; step(); pop = 1'b0;
      chk("pre_rst_count", 64'(count64), 64'd2);
      rst_n = 1'b0;
      #2;
      chk("arst_flags64", {58'd0, count64, empty64, full64, alm64}, {58'd0, 3'd0, 3'b100});
      chk("arst_data64", data64, 64'd0);
      #2 rst_n = 1'b1;
      step();
      push = 1'b1; pd64 = 64'hFFFFFFFF_AABBCCDD; step(); push = 1'b0;
      chk("arst_cfg_word", data64, 64'h00000000_AABBCCDD);

      // Randomized run on the 32-bit instance against the queue model
      begin_xfer(2'd2, 1'b0, 2'd0, 3'd0);
      mq.delete(); m_es = 1; m_ptr = 0; m_sx = 1'b0;
      for (int c = 0; c < 400; c++) begin
         exp_d = (mq.size() == 0) ? 32'h0 : model_elem(mq[0], m_ptr, m_es, m_sx);
         chk($sformatf("rnd%0d_data", c), 64'(data32), 64'(exp_d));
         chk($sformatf("rnd%0d_stat", c), {58'd0, count32, empty32, full32, alm32},
             {58'd0, 3'(mq.size()), mq.size() == 0, mq.size() == 4, mq.size() >= 3});
         r_f    = ($urandom_range(0, 24) == 0);
         r_s    = r_f && ($urandom_range(0, 1) == 1);
         r_push = ($urandom_range(0, 9) < 6);
         r_pop  = ($urandom_range(0, 9) < 6);
         r_dt   = 2'($urandom_range(0, 3));
         r_off  = 2'($urandom_range(0, 3));
         r_d    = $urandom;
         flush = r_f; start = r_s; push = r_push; pop = r_pop;
         dt = r_dt; off32 = r_off; pd32 = r_d; sx = 1'($urandom_range(0, 1));
         step();
         n = mq.size();
         if (r_f) begin
            mq.delete();
            m_ptr = 0;
            if (r_s) begin
               m_es  = es_of(r_dt);
               m_sx  = sx;
               m_ptr = int'(r_off) - (int'(r_off) % m_es);
            end
         end else begin
            if (r_pop && n > 0) begin
               if (m_ptr + m_es == 4) begin
                  void'(mq.pop_front());
                  m_ptr = 0;
               end else begin
                  m_ptr = m_ptr + m_es;
               end
            end
            if (r_push && n < 4) mq.push_back(r_d);
         end
      end
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dma_buffer_packer.md
# dma_buffer_packer

Parametrised read-side buffer for the DMA read path. It stores full-width memory words in an internal FIFO and hands them to the write side one element at a time. Elements are bytes, halfwords, words or doublewords, with optional sign extension and a start-byte offset. It replaces the fixed 32-bit, 4-lane read FIFO and control pair, generalising data width and depth and adding sign extension and a misaligned start.

## Interface
Parameters:
- DATA_WIDTH, 32: memory word width; legal values 32 or 64. BYTES = DATA_WIDTH/8.
- FIFO_DEPTH, 4: word entries; must be a power of two, ≥2.
- OFF_W, $clog2(BYTES): width of the byte pointer and offset.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  one-cycle pulse that latches data_type_i, sign_ext_i and src_offset_i.
- data_type_i  in  2  element size: 0 word, 1 halfword, 2 byte, 3 doubleword (DATA_WIDTH=64 only; otherwise treated as word).
- sign_ext_i  in  1  1 = sign-extend the element to DATA_WIDTH; 0 = zero-extend.
- src_offset_i  in  OFF_W  start byte within the first word.
- flush_i  in  1  synchronous clear.
- push_i  in  1  write a word from the read master.
- push_data_i  in  DATA_WIDTH  word to write.
- full_o  out  1  FIFO holds FIFO_DEPTH words.
- alm_full_o  out  1  count ≥ FIFO_DEPTH-1.
- pop_i  in  1  consume the current element.
- empty_o  out  1  no element available.
- data_o  out  DATA_WIDTH  current element, extended.
- count_o  out  $clog2(FIFO_DEPTH+1)  words stored.

## Operation
- Word FIFO uses registered storage with read/write pointers and a count register. Head word = entry at the read pointer.
- Config registers esize (1/2/4/8 bytes), sext and byte pointer ptr load only on start_i.
  - ptr loads src_offset_i aligned down to esize, i.e. low bits are cleared.
  - Config held between starts; port changes without start_i are ignored.
- data_o = head bytes [ptr +: esize], extended per sext. When empty_o=1, data_o is 0.
- Pop with empty_o=0:
  - If ptr+esize == BYTES: the head word retires and ptr returns to 0.
  - Otherwise ptr advances by esize.
  - Pop with empty_o=1 is ignored.
- Push with full_o=0 writes push_data_i at the write pointer. Push with full_o=1 is dropped, even if a word retires in the same cycle.
- Simultaneous accepted push and word-retiring pop leaves count unchanged.
- flush_i clears both pointers, count and ptr to 0, and takes priority over push and pop in that cycle.
  - If start_i is also high, config loads and ptr takes the aligned offset.
  - Config registers are not cleared by flush.
- Elements never straddle words; the natural-alignment guarantee comes from the DMA address checks.
- Pointer arithmetic is modulo FIFO_DEPTH. ptr arithmetic is done in OFF_W+1 bits to detect the end of a word.

## Timing
- Reset values:
  - count_o=0, empty_o=1, full_o=0, alm_full_o=0, data_o=0.
  - ptr=0; config = word, zero-extend.
- Push latency is 1 cycle: a word pushed in cycle n is visible on data_o and empty_o=0 in cycle n+1. There is no fall-through.
- data_o, empty_o, full_o, alm_full_o and count_o are combinational from registers only; there is no path from pop_i or push_i.
- Pop takes effect at the clock edge. The next element appears in the following cycle, giving one element per cycle sustained.
- Reset mid-transfer discards all words and config immediately, without waiting for the clock.

## Test plan
- DATA_WIDTH=32, byte mode, offset 0: push 0x44332211, then pop 4× on consecutive cycles → data_o 0x11, 0x22, 0x33, 0x44. count_o reaches 0 after the 4th pop, and empty_o=1 the next cycle.
- Halfword with sign_ext=1: push 0x80017FFF and pop 2× → 0x00007FFF, 0xFFFF8001. Repeat with sign_ext=0 → second element 0x00008001.
- Byte mode, src_offset=2: push 0x44332211, 0x88776655 and pop 4× → 0x33, 0x44, 0x55, 0x66. Halfword with offset 3 → first element 0x4433.
- DEPTH=4: push 5 words without popping → alm_full_o=1 after the 3rd, full_o=1 after the 4th, 5th dropped. The 5th push repeated with a retiring pop in the same cycle is still dropped, and count_o=3.
- Flush mid-word: byte mode, 2 words stored, pop 1 → assert flush_i with push_i high → count_o=0, empty_o=1, and the pushed word is discarded. The next push then pop → byte 0 of the new word.
- DATA_WIDTH=64, doubleword with sign_ext=1: push 0x8000000000000001 → data_o equals the word. Byte mode → 8 pops then retire. Assert rst_ni low mid-stream → all outputs at reset values before the next edge.
